// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operands and strobe in, registered result and status out.
interface seq_alu_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
);
  logic                   start_i;
  logic [4:0]             alu_operation_i;
  logic [DATA_WIDTH-1:0]  a_i;
  logic [DATA_WIDTH-1:0]  b_i;
  logic [SHAMT_WIDTH-1:0] shamt_i;
  logic                   ready_o;
  logic                   valid_o;
  logic [DATA_WIDTH-1:0]  result_lo_o;
  logic [DATA_WIDTH-1:0]  result_hi_o;
  logic                   zero_o;
  logic                   overflow_o;
  logic                   div_zero_o;
  logic                   illegal_o;

  modport master (
    output start_i, alu_operation_i, a_i, b_i, shamt_i,
    input  ready_o, valid_o, result_lo_o, result_hi_o,
           zero_o, overflow_o, div_zero_o, illegal_o
  );

  modport slave (
    input  start_i, alu_operation_i, a_i, b_i, shamt_i,
    output ready_o, valid_o, result_lo_o, result_hi_o,
           zero_o, overflow_o, div_zero_o, illegal_o
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative shift-add multiply.
// Define SEQ_ALU_DIV_EN to add the iterative restoring divider (DIV/DIVU).
module seq_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic     clk,
  input  logic     reset,
  seq_alu_if.slave bus
);
  localparam int MSB   = DATA_WIDTH - 1;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  localparam logic [4:0] OP_ADD  = 5'b00000, OP_SUB   = 5'b00001, OP_OR    = 5'b00010;
  localparam logic [4:0] OP_SLL  = 5'b00101, OP_SRL   = 5'b00100, OP_SRA   = 5'b10001;
  localparam logic [4:0] OP_AND  = 5'b01101, OP_NOR   = 5'b01100, OP_XOR   = 5'b10010;
  localparam logic [4:0] OP_SLT  = 5'b10011, OP_SLTU  = 5'b10100, OP_MULT  = 5'b10101;
  localparam logic [4:0] OP_MULTU = 5'b10110, OP_DIV  = 5'b10111, OP_DIVU  = 5'b11000;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   hi_reg, lo_reg, mcand_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    neg_q_reg;
  logic [DATA_WIDTH-1:0]   res_lo_reg, res_hi_reg;
  logic                    zero_reg, ovf_reg, div0_out_reg, illegal_reg;
`ifdef SEQ_ALU_DIV_EN
  logic                    is_mul_reg, neg_r_reg, div0_reg, div_ovf_reg;
  logic [DATA_WIDTH:0]     div_shift, div_diff;
`endif

  logic                    ready, valid, last_iter;
  logic [DATA_WIDTH-1:0]   a, b, sc_lo, a_mag, b_mag;
  logic                    sc_ovf, sc_illegal, long_op, a_neg, b_neg;
  logic [DATA_WIDTH:0]     mul_sum;
  logic [DATA_WIDTH-1:0]   iter_hi, iter_lo, fin_hi, fin_lo;
  logic [2*DATA_WIDTH-1:0] prod_fix;
  logic                    fin_ovf, fin_div0;

  assign a         = bus.a_i;
  assign b         = bus.b_i;
  assign last_iter = (cnt_reg == CNT_W'(DATA_WIDTH - 1));

  // Decode at the request boundary: single-cycle result and long-op classification.
  always_comb begin
    sc_lo      = '0;
    sc_ovf     = 1'b0;
    sc_illegal = 1'b0;
    long_op    = 1'b0;
    case (bus.alu_operation_i)
      OP_ADD: begin
        sc_lo  = a + b;
        sc_ovf = (a[MSB] == b[MSB]) && (sc_lo[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sc_lo  = a - b;
        sc_ovf = (a[MSB] != b[MSB]) && (sc_lo[MSB] != a[MSB]);
      end
      OP_OR:    sc_lo = a | b;
      OP_AND:   sc_lo = a & b;
      OP_NOR:   sc_lo = ~(a | b);
      OP_XOR:   sc_lo = a ^ b;
      OP_SLL:   sc_lo = b << bus.shamt_i;
      OP_SRL:   sc_lo = b >> bus.shamt_i;
      OP_SRA:   sc_lo = $signed(b) >>> bus.shamt_i;
      OP_SLT:   sc_lo = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:  sc_lo = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      OP_MULT, OP_MULTU: long_op = 1'b1;
`ifdef SEQ_ALU_DIV_EN
      OP_DIV, OP_DIVU:   long_op = 1'b1;
`endif
      default:  sc_illegal = 1'b1;
    endcase
    a_neg = ((bus.alu_operation_i == OP_MULT) || (bus.alu_operation_i == OP_DIV)) && a[MSB];
    b_neg = ((bus.alu_operation_i == OP_MULT) || (bus.alu_operation_i == OP_DIV)) && b[MSB];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // One multiply or divide step, plus the sign/zero fix-up applied on the last step.
  always_comb begin
    mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mcand_reg} : {(DATA_WIDTH+1){1'b0}});
    iter_hi = mul_sum[DATA_WIDTH:1];
    iter_lo = {mul_sum[0], lo_reg[MSB:1]};
`ifdef SEQ_ALU_DIV_EN
    div_shift = {hi_reg, lo_reg[MSB]};
    div_diff  = div_shift - {1'b0, mcand_reg};
    if (!is_mul_reg) begin
      iter_hi = div_diff[DATA_WIDTH] ? div_shift[MSB:0] : div_diff[MSB:0];
      iter_lo = {lo_reg[MSB-1:0], ~div_diff[DATA_WIDTH]};
    end
`endif
    prod_fix = neg_q_reg ? -{iter_hi, iter_lo} : {iter_hi, iter_lo};
    fin_hi   = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
    fin_lo   = prod_fix[MSB:0];
    fin_ovf  = 1'b0;
    fin_div0 = 1'b0;
`ifdef SEQ_ALU_DIV_EN
    // Divide-by-zero naturally leaves |a| as the remainder; sign restore turns it back into a.
    if (!is_mul_reg) begin
      fin_lo   = div0_reg ? {DATA_WIDTH{1'b1}} : (neg_q_reg ? -iter_lo : iter_lo);
      fin_hi   = neg_r_reg ? -iter_hi : iter_hi;
      fin_ovf  = div_ovf_reg;
      fin_div0 = div0_reg;
    end
`endif
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    valid      = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (bus.start_i) state_next = long_op ? BUSY : DONE;
      end
      BUSY: if (last_iter) state_next = DONE;
      DONE: begin
        valid      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      hi_reg       <= '0;
      lo_reg       <= '0;
      mcand_reg    <= '0;
      cnt_reg      <= '0;
      neg_q_reg    <= 1'b0;
      res_lo_reg   <= '0;
      res_hi_reg   <= '0;
      zero_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      div0_out_reg <= 1'b0;
      illegal_reg  <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      is_mul_reg   <= 1'b0;
      neg_r_reg    <= 1'b0;
      div0_reg     <= 1'b0;
      div_ovf_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && bus.start_i) begin
        if (long_op) begin
          hi_reg    <= '0;
          lo_reg    <= a_mag;
          mcand_reg <= b_mag;
          cnt_reg   <= '0;
          neg_q_reg <= a_neg ^ b_neg;
`ifdef SEQ_ALU_DIV_EN
          is_mul_reg  <= (bus.alu_operation_i == OP_MULT) || (bus.alu_operation_i == OP_MULTU);
          neg_r_reg   <= a_neg;
          div0_reg    <= (b == '0);
          div_ovf_reg <= (bus.alu_operation_i == OP_DIV) && (a == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                         && (b == {DATA_WIDTH{1'b1}});
`endif
        end else begin
          res_lo_reg   <= sc_lo;
          res_hi_reg   <= '0;
          zero_reg     <= (sc_lo == '0);
          ovf_reg      <= sc_ovf;
          div0_out_reg <= 1'b0;
          illegal_reg  <= sc_illegal;
        end
      end else if (state_reg == BUSY) begin
        hi_reg  <= iter_hi;
        lo_reg  <= iter_lo;
        cnt_reg <= cnt_reg + CNT_W'(1);
        if (last_iter) begin
          res_lo_reg   <= fin_lo;
          res_hi_reg   <= fin_hi;
          zero_reg     <= (fin_lo == '0);
          ovf_reg      <= fin_ovf;
          div0_out_reg <= fin_div0;
          illegal_reg  <= 1'b0;
        end
      end
    end
  end

  assign bus.ready_o     = ready;
  assign bus.valid_o     = valid;
  assign bus.result_lo_o = res_lo_reg;
  assign bus.result_hi_o = res_hi_reg;
  assign bus.zero_o      = zero_reg;
  assign bus.overflow_o  = ovf_reg;
  assign bus.div_zero_o  = div0_out_reg;
  assign bus.illegal_o   = illegal_reg;
endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at DATA_WIDTH=32; divide tests follow SEQ_ALU_DIV_EN.
module tb_seq_alu;
  localparam logic [4:0] OP_ADD  = 5'b00000, OP_SUB  = 5'b00001, OP_OR   = 5'b00010;
  localparam logic [4:0] OP_SLL  = 5'b00101, OP_SRL  = 5'b00100, OP_SRA  = 5'b10001;
  localparam logic [4:0] OP_AND  = 5'b01101, OP_NOR  = 5'b01100, OP_XOR  = 5'b10010;
  localparam logic [4:0] OP_SLT  = 5'b10011, OP_SLTU = 5'b10100, OP_MULT = 5'b10101;
  localparam logic [4:0] OP_MULTU = 5'b10110, OP_DIV = 5'b10111, OP_DIVU = 5'b11000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seq_alu_if #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) bus ();
  seq_alu #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic [31:0] lo;
    logic        ovf, zero, ill;
  } vec_t;

  // Issues one request and counts falling edges until valid_o; optional stray strobes mid-operation.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input bit pulse_busy,
                        output int cycles, output bit ready_in_busy);
    @(negedge clk);
    bus.start_i = 1'b1; bus.alu_operation_i = op; bus.a_i = a; bus.b_i = b; bus.shamt_i = sh;
    cycles = 0;
    ready_in_busy = 1'b0;
    do begin
      @(negedge clk);
      cycles++;
      bus.start_i = 1'b0;
      if (pulse_busy && (cycles == 5 || cycles == 10)) begin
        ready_in_busy |= bus.ready_o;
        bus.start_i = 1'b1; bus.alu_operation_i = OP_ADD; bus.a_i = 32'd1; bus.b_i = 32'd1;
      end
    end while (!bus.valid_o && cycles < 100);
    bus.start_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.start_i = 1'b0; bus.alu_operation_i = '0; bus.a_i = '0; bus.b_i = '0; bus.shamt_i = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.ready_o, bus.valid_o} !== 2'b10) begin
      errors++; $display("FAIL reset_handshake: got ready/valid=%b, need 10", {bus.ready_o, bus.valid_o});
    end
    checks++;
    if ({bus.result_lo_o, bus.result_hi_o, bus.zero_o, bus.overflow_o, bus.div_zero_o, bus.illegal_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: lo=%h hi=%h flags=%b, need all 0", bus.result_lo_o, bus.result_hi_o,
                         {bus.zero_o, bus.overflow_o, bus.div_zero_o, bus.illegal_o});
    end
    reset = 1'b0;
    $display("reset: ready=%b valid=%b lo=%h", bus.ready_o, bus.valid_o, bus.result_lo_o);
  endtask

  task automatic test_add_overflow();
    int cyc; bit rb;
    run_op(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0, cyc, rb);
    $display("ADD 7fffffff+1: cycles=%0d lo=%h ovf=%b zero=%b", cyc, bus.result_lo_o, bus.overflow_o, bus.zero_o);
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL add_latency: got %0d, need 1", cyc); end
    checks++;
    if ({bus.result_lo_o, bus.result_hi_o, bus.overflow_o, bus.zero_o} !== {32'h8000_0000, 32'h0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL add_overflow: lo=%h hi=%h ovf=%b zero=%b, need 80000000 0 1 0",
                         bus.result_lo_o, bus.result_hi_o, bus.overflow_o, bus.zero_o);
    end
    @(negedge clk);
    checks++;
    if ({bus.valid_o, bus.result_lo_o, bus.overflow_o} !== {1'b0, 32'h8000_0000, 1'b1}) begin
      errors++; $display("FAIL add_hold: valid=%b lo=%h ovf=%b, need 0 80000000 1", bus.valid_o, bus.result_lo_o, bus.overflow_o);
    end
  endtask

  task automatic test_single_cycle();
    vec_t v[13];
    int cyc; bit rb;
    v[0]  = '{OP_SUB,   32'd5,          32'd7,          5'd0,  32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    v[1]  = '{OP_SUB,   32'h8000_0000,  32'd1,          5'd0,  32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0};
    v[2]  = '{OP_OR,    32'hF0F0_0000,  32'h0000_0F0F,  5'd0,  32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0};
    v[3]  = '{OP_AND,   32'hFF00_FF00,  32'h0F0F_0F0F,  5'd0,  32'h0F00_0F00, 1'b0, 1'b0, 1'b0};
    v[4]  = '{OP_NOR,   32'hFF00_FF00,  32'h00FF_00FF,  5'd0,  32'h0000_0000, 1'b0, 1'b1, 1'b0};
    v[5]  = '{OP_XOR,   32'hAAAA_5555,  32'hFFFF_0000,  5'd0,  32'h5555_5555, 1'b0, 1'b0, 1'b0};
    v[6]  = '{OP_SLL,   32'h0,          32'h0000_0001,  5'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
    v[7]  = '{OP_SRL,   32'h0,          32'h8000_0000,  5'd4,  32'h0800_0000, 1'b0, 1'b0, 1'b0};
    v[8]  = '{OP_SRA,   32'h0,          32'h8000_0000,  5'd4,  32'hF800_0000, 1'b0, 1'b0, 1'b0};
    v[9]  = '{OP_SLT,   32'hFFFF_FFFF,  32'd1,          5'd0,  32'h0000_0001, 1'b0, 1'b0, 1'b0};
    v[10] = '{OP_SLTU,  32'hFFFF_FFFF,  32'd1,          5'd0,  32'h0000_0000, 1'b0, 1'b1, 1'b0};
    v[11] = '{OP_ADD,   32'hFFFF_FFFF,  32'd1,          5'd0,  32'h0000_0000, 1'b0, 1'b1, 1'b0};
    v[12] = '{5'b11111, 32'h1234_5678,  32'h9ABC_DEF0,  5'd3,  32'h0000_0000, 1'b0, 1'b1, 1'b1};
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].sh, 1'b0, cyc, rb);
      $display("op=%b a=%h b=%h sh=%0d: cycles=%0d lo=%h hi=%h ovf=%b zero=%b ill=%b", v[i].op, v[i].a, v[i].b,
               v[i].sh, cyc, bus.result_lo_o, bus.result_hi_o, bus.overflow_o, bus.zero_o, bus.illegal_o);
      checks++;
      if ({cyc == 1, bus.result_lo_o, bus.result_hi_o, bus.overflow_o, bus.zero_o, bus.illegal_o, bus.div_zero_o} !==
          {1'b1, v[i].lo, 32'h0, v[i].ovf, v[i].zero, v[i].ill, 1'b0}) begin
        errors++; $display("FAIL single_cycle[%0d]: cycles=%0d lo=%h hi=%h ovf=%b zero=%b ill=%b, need 1 %h 0 %b %b %b",
                           i, cyc, bus.result_lo_o, bus.result_hi_o, bus.overflow_o, bus.zero_o, bus.illegal_o,
                           v[i].lo, v[i].ovf, v[i].zero, v[i].ill);
      end
    end
  endtask

  task automatic check_long(input string name, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int exp_cyc, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                            input logic exp_ovf, input logic exp_div0, input logic exp_ill, input bit pulse);
    int cyc; bit rb;
    run_op(op, a, b, 5'd0, pulse, cyc, rb);
    $display("%s a=%h b=%h: cycles=%0d hi=%h lo=%h ovf=%b dz=%b ill=%b zero=%b", name, a, b, cyc, bus.result_hi_o,
             bus.result_lo_o, bus.overflow_o, bus.div_zero_o, bus.illegal_o, bus.zero_o);
    checks++;
    if (cyc !== exp_cyc || rb !== 1'b0) begin
      errors++; $display("FAIL %s_latency: cycles=%0d ready_in_busy=%b, need %0d 0", name, cyc, rb, exp_cyc);
    end
    checks++;
    if ({bus.result_hi_o, bus.result_lo_o, bus.overflow_o, bus.div_zero_o, bus.illegal_o, bus.zero_o} !==
        {exp_hi, exp_lo, exp_ovf, exp_div0, exp_ill, exp_lo == 32'h0}) begin
      errors++; $display("FAIL %s_result: hi=%h lo=%h ovf=%b dz=%b ill=%b zero=%b, need %h %h %b %b %b %b", name,
                         bus.result_hi_o, bus.result_lo_o, bus.overflow_o, bus.div_zero_o, bus.illegal_o, bus.zero_o,
                         exp_hi, exp_lo, exp_ovf, exp_div0, exp_ill, exp_lo == 32'h0);
    end
  endtask

  task automatic test_mult();
    check_long("mult_neg2x3", OP_MULT, 32'hFFFF_FFFE, 32'd3, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b0, 1'b0, 1'b1);
    check_long("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    check_long("mult_neg3xneg5", OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 33, 32'h0, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef SEQ_ALU_DIV_EN
  task automatic test_div();
    check_long("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 1'b1);
    check_long("divu_by0", OP_DIVU, 32'd5, 32'd0, 33, 32'd5, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    check_long("div_min_by_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    check_long("divu_100by7", OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
`else
  task automatic test_div_disabled();
    check_long("div_disabled", OP_DIV, 32'd6, 32'd3, 1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_long("divu_disabled", OP_DIVU, 32'd5, 32'd0, 1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask
`endif

  task automatic test_reset_mid_busy();
    int cyc; bit rb; int stray;
    @(negedge clk);
    bus.start_i = 1'b1; bus.alu_operation_i = OP_MULTU; bus.a_i = 32'd3; bus.b_i = 32'd4;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    $display("reset mid-MULTU: ready=%b valid=%b lo=%h hi=%h", bus.ready_o, bus.valid_o, bus.result_lo_o, bus.result_hi_o);
    checks++;
    if ({bus.ready_o, bus.valid_o, bus.result_lo_o, bus.result_hi_o, bus.zero_o, bus.overflow_o, bus.div_zero_o,
         bus.illegal_o} !== {1'b1, 1'b0, 64'h0, 4'h0}) begin
      errors++; $display("FAIL reset_mid_busy: ready=%b valid=%b lo=%h hi=%h, need 1 0 0 0 flags 0",
                         bus.ready_o, bus.valid_o, bus.result_lo_o, bus.result_hi_o);
    end
    @(negedge clk);
    reset = 1'b0;
    run_op(OP_ADD, 32'd2, 32'd3, 5'd0, 1'b0, cyc, rb);
    $display("ADD 2+3 after reset: cycles=%0d lo=%h", cyc, bus.result_lo_o);
    checks++;
    if (cyc !== 1 || bus.result_lo_o !== 32'd5) begin
      errors++; $display("FAIL add_after_reset: cycles=%0d lo=%h, need 1 00000005", cyc, bus.result_lo_o);
    end
    stray = 0;
    repeat (40) begin @(negedge clk); if (bus.valid_o) stray++; end
    checks++;
    if (stray !== 0 || bus.result_lo_o !== 32'd5) begin
      errors++; $display("FAIL no_stale_result: valid pulses=%0d lo=%h, need 0 00000005", stray, bus.result_lo_o);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit rb;
    run_op(OP_SUB, 32'd10, 32'd3, 5'd0, 1'b0, cyc, rb);
    $display("SUB 10-3: cycles=%0d lo=%h", cyc, bus.result_lo_o);
    checks++;
    if (cyc !== 1 || bus.result_lo_o !== 32'd7) begin
      errors++; $display("FAIL b2b_sub: cycles=%0d lo=%h, need 1 00000007", cyc, bus.result_lo_o);
    end
    run_op(OP_MULTU, 32'd6, 32'd7, 5'd0, 1'b0, cyc, rb);
    $display("MULTU 6*7: cycles=%0d lo=%h", cyc, bus.result_lo_o);
    checks++;
    if (cyc !== 33 || {bus.result_hi_o, bus.result_lo_o} !== 64'd42) begin
      errors++; $display("FAIL b2b_multu: cycles=%0d hi=%h lo=%h, need 33 0 0000002a", cyc, bus.result_hi_o, bus.result_lo_o);
    end
    run_op(OP_XOR, 32'hFFFF_FFFF, 32'h0000_FFFF, 5'd0, 1'b0, cyc, rb);
    $display("XOR: cycles=%0d lo=%h hi=%h", cyc, bus.result_lo_o, bus.result_hi_o);
    checks++;
    if (cyc !== 1 || bus.result_lo_o !== 32'hFFFF_0000 || bus.result_hi_o !== 32'h0) begin
      errors++; $display("FAIL b2b_xor: cycles=%0d lo=%h hi=%h, need 1 ffff0000 0", cyc, bus.result_lo_o, bus.result_hi_o);
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_single_cycle();
    test_mult();
`ifdef SEQ_ALU_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_reset_mid_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (legal 8..64, even).
REQ-002 SHALL have parameter SHAMT_WIDTH, default $clog2(DATA_WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start_i  input  1  request strobe; accepted only when ready_o=1.
REQ-006 SHALL have port alu_operation_i  input  5  opcode, sampled at acceptance.
REQ-007 SHALL have ports a_i, b_i  input  DATA_WIDTH  operands, sampled at acceptance.
REQ-008 SHALL have port shamt_i  input  SHAMT_WIDTH  shift amount, sampled at acceptance.
REQ-009 SHALL have port ready_o  output  1  high only in IDLE.
REQ-010 SHALL have port valid_o  output  1  one-cycle pulse marking new result.
REQ-011 SHALL have ports result_lo_o, result_hi_o  output  DATA_WIDTH  registered result (lo=product low/quotient; hi=product high/remainder).
REQ-012 SHALL have ports zero_o, overflow_o, div_zero_o, illegal_o  output  1  registered status, updated with valid_o.

Function
REQ-013 Opcodes SHALL be: ADD 00000, SUB 00001, OR 00010, SLL 00101, SRL 00100, SRA 10001, AND 01101, NOR 01100, XOR 10010, SLT 10011, SLTU 10100, MULT 10101, MULTU 10110, DIV 10111, DIVU 11000.
REQ-014 FSM states SHALL be IDLE, BUSY, DONE; IDLE->DONE on start_i for single-cycle ops; IDLE->BUSY on start_i for MULT/MULTU/DIV/DIVU; BUSY->DONE after DATA_WIDTH iterations; DONE->IDLE unconditionally.
REQ-015 valid_o SHALL be high exactly in DONE; single-cycle latency start->valid_o = 1 cycle; multiply/divide latency = DATA_WIDTH+1 cycles.
REQ-016 start_i while ready_o=0 SHALL be ignored with no effect on the operation in flight.
REQ-017 Results and flags SHALL hold their values until the next DONE.
REQ-018 Single-cycle ops SHALL write result_hi_o = 0; SLT/SLTU write 1 or 0 in result_lo_o.
REQ-019 ADD/SUB SHALL wrap modulo 2^DATA_WIDTH; overflow_o = signed two's-complement overflow; 0 for all other single-cycle ops.
REQ-020 Shifts SHALL shift b_i by shamt_i; SRA sign-fills.
REQ-021 Multiply SHALL be iterative shift-add over DATA_WIDTH cycles giving full 2*DATA_WIDTH product; MULT signed via magnitude plus final negate.
REQ-022 Divide SHALL be iterative restoring over DATA_WIDTH cycles; DIV quotient truncates toward zero, remainder takes dividend's sign.
REQ-023 Divide by zero SHALL give result_lo_o all ones, result_hi_o = a_i, div_zero_o=1, same latency.
REQ-024 DIV of most-negative by -1 SHALL give quotient = most-negative, remainder 0, overflow_o=1.
REQ-025 zero_o SHALL be 1 when result_lo_o == 0.
REQ-026 Unlisted opcodes SHALL complete as single-cycle ops with results 0, illegal_o=1, zero_o=1.

Reset
REQ-027 reset SHALL force IDLE immediately, including mid-BUSY, discarding the operation in flight.
REQ-028 Under reset, ready_o SHALL be 1 and valid_o, result_lo_o, result_hi_o and all flags SHALL be 0.

Configuration
REQ-029 With macro SEQ_ALU_DIV_EN defined, DIV/DIVU SHALL be implemented per REQ-022..024.
REQ-030 Without SEQ_ALU_DIV_EN, DIV/DIVU SHALL be treated as illegal per REQ-026 and no divider logic SHALL exist.

Verification (DATA_WIDTH=32)
REQ-031 ADD a=0x7FFFFFFF b=1 -> valid_o one cycle later, lo=0x80000000, overflow_o=1, zero_o=0.
REQ-032 MULT a=0xFFFFFFFE(-2) b=3 -> valid_o at cycle 33, hi=0xFFFFFFFF lo=0xFFFFFFFA; start_i pulses during BUSY ignored.
REQ-033 DIV a=-7 b=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=5, div_zero_o=1.
REQ-034 DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, overflow_o=1.
REQ-035 Assert reset at cycle 10 of MULTU -> ready_o=1, outputs 0 immediately; next ADD 2+3 -> lo=5.
REQ-036 Build without SEQ_ALU_DIV_EN; DIV 6/3 -> valid_o after 1 cycle, illegal_o=1, lo=0.
